ahfp_add_arbiter: RTL and testbench
===================================

AHFP_ADD_ARBITER -- requirements
Module: ahfp_add_arbiter

Interface
REQ-001 Parameter: N, default 4, number of requesters sharing one pipelined FP adder.
REQ-002 Parameter: LATENCY, default 7, cycles from fp_dataa/fp_datab valid to matching fp_result.
REQ-003 Parameter: MAX_OUT, default 4, max in-flight ops per requester.
REQ-004 Port: clk  in  1  sole clock, all state on rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: req_valid  in  N  request i presents an operation.
REQ-007 Port: req_ready  out  N  one-hot grant; handshake when req_valid[i] and req_ready[i] are both high.
REQ-008 Port: req_dataa  in  32*N  operand A of requester i, bits [32i+31:32i].
REQ-009 Port: req_datab  in  32*N  operand B of requester i, same slicing.
REQ-010 Port: rsp_valid  out  N  one-cycle pulse, result for requester i.
REQ-011 Port: rsp_result  out  32  result word, valid while any rsp_valid bit is high.
REQ-012 Port: fp_dataa, fp_datab  out  32 each  registered operands to the shared adder.
REQ-013 Port: fp_result  in  32  adder output.
REQ-014 Port: busy  out  1  high while any operation is in flight.

Function
REQ-015 Round-robin arbitration; pointer ptr starts at 0; grant the first i at or after ptr (mod N) with req_valid[i]=1 and outstanding[i]<MAX_OUT.
REQ-016 At most one req_ready bit high per cycle; req_ready is combinational from req_valid, ptr and counters.
REQ-017 On handshake with requester g, ptr becomes (g+1) mod N next cycle; ptr unchanged with no handshake.
REQ-018 On handshake, fp_dataa/fp_datab register the granted operands next edge; with no handshake they register 32'd0.
REQ-019 Tag pipeline, LATENCY+1 stages, carries {valid, requester id}; stage 0 loads on handshake.
REQ-020 When the tag exits, rsp_valid[id] pulses one cycle and rsp_result = fp_result that cycle; handshake-to-rsp_valid latency is exactly LATENCY+1 cycles.
REQ-021 Back-to-back handshakes every cycle are supported; throughput one op per cycle.
REQ-022 outstanding[i] increments on handshake i, decrements on rsp_valid[i], unchanged when both occur same cycle; never exceeds MAX_OUT or wraps below 0.
REQ-023 Responses are not back-pressured; requesters must accept rsp_valid when it arrives.
REQ-024 busy = OR of all tag-stage valid bits.

Reset
REQ-025 While rst_n low: ptr=0, all tag valids 0, outstanding counters 0, fp_dataa=fp_datab=0, rsp_valid=0, busy=0, req_ready=0.
REQ-026 Reset mid-operation discards in-flight ops; no rsp_valid pulse for them after reset release.
REQ-027 First grant possible in the first cycle rst_n is high.

Configuration
REQ-028 Macro AHFP_ARB_SUB_EN: when defined, adds input port req_op (N bits; 1 = subtract A-B), and bit 31 of the granted datab is inverted before registering into fp_datab.
REQ-029 Without AHFP_ARB_SUB_EN: no req_op port, operands pass unmodified, add only.

Verification
REQ-030 Requester 0 alone, A=0x3FC00000 (1.5), B=0x40200000 (2.5) -> rsp_valid[0] exactly 8 cycles after handshake, rsp_result=0x40800000.
REQ-031 All four req_valid held high from reset release -> grants 0,1,2,3,0,... on consecutive cycles, responses in same order 8 cycles later.
REQ-032 Requester 2 holds req_valid continuously, others idle -> 4 grants, req_ready[2] low until first rsp_valid[2], then one grant per response.
REQ-033 rst_n pulsed low 3 cycles after two handshakes -> no rsp_valid ever for those ops, busy=0, fp_dataa=0.
REQ-034 With AHFP_ARB_SUB_EN, req_op[1]=1, A=0x40400000 (3.0), B=0x3F800000 (1.0) -> fp_datab=0xBF800000, rsp_result=0x40000000 (2.0).
REQ-035 Grant and response to the same requester in the same cycle at outstanding=MAX_OUT -> counter stays 4, no overflow.

Source files
------------

// File: rtl/ahfp_add_arbiter.sv
// Round-robin arbiter sharing one pipelined FP adder among N requesters, with per-requester credit limits.
// Optional build macro AHFP_ARB_SUB_EN adds a per-requester req_op input that selects subtract (A-B).
module ahfp_add_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned LATENCY = 7,
   parameter int unsigned MAX_OUT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_valid,
   output logic [N-1:0]    req_ready,
   input  logic [32*N-1:0] req_dataa,
   input  logic [32*N-1:0] req_datab,
`ifdef AHFP_ARB_SUB_EN
   input  logic [N-1:0]    req_op,
`endif
   output logic [N-1:0]    rsp_valid,
   output logic [31:0]     rsp_result,
   output logic [31:0]     fp_dataa,
   output logic [31:0]     fp_datab,
   input  logic [31:0]     fp_result,
   output logic            busy
);

   localparam int unsigned ID_W  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

   logic [ID_W-1:0]  ptr;
   logic [CNT_W-1:0] outstanding [N];
   logic [LATENCY:0] tag_valid;
   logic [ID_W-1:0]  tag_id [LATENCY+1];

   logic [N-1:0]     eligible_c;
   logic [N-1:0]     hs_c;
   logic             grant_any_c;
   logic [ID_W-1:0]  grant_id_c;
   logic [ID_W-1:0]  cand_c;
   logic [31:0]      opa_c;
   logic [31:0]      opb_c;

   // A response in the same cycle frees a slot, so a full requester can be regranted immediately.
   always_comb begin
      eligible_c = '0;
      for (int i = 0; i < int'(N); i++) begin
         eligible_c[i] = rst_n && req_valid[i] &&
                         ((outstanding[i] < CNT_W'(MAX_OUT)) || rsp_valid[i]);
      end
   end

   // First eligible requester at or after ptr, wrapping modulo N.
   always_comb begin
      req_ready   = '0;
      grant_any_c = 1'b0;
      grant_id_c  = '0;
      cand_c      = '0;
      for (int k = 0; k < int'(N); k++) begin
         cand_c = ID_W'((32'(ptr) + 32'(k)) % N);
         if (!grant_any_c && eligible_c[cand_c]) begin
            grant_any_c = 1'b1;
            grant_id_c  = cand_c;
         end
      end
      if (grant_any_c) begin
         req_ready[grant_id_c] = 1'b1;
      end
   end

   assign hs_c = req_valid & req_ready;

   always_comb begin
      opa_c = req_dataa[32*grant_id_c +: 32];
      opb_c = req_datab[32*grant_id_c +: 32];
`ifdef AHFP_ARB_SUB_EN
      if (req_op[grant_id_c]) begin
         opb_c[31] = ~opb_c[31];
      end
`endif
   end

   // Pointer, operand registers and the tag pipeline that tracks ops through the adder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         fp_dataa  <= '0;
         fp_datab  <= '0;
         tag_valid <= '0;
         for (int s = 0; s <= int'(LATENCY); s++) begin
            tag_id[s] <= '0;
         end
      end else begin
         if (grant_any_c) begin
            ptr      <= (grant_id_c == ID_W'(N - 1)) ? '0 : grant_id_c + ID_W'(1);
            fp_dataa <= opa_c;
            fp_datab <= opb_c;
         end else begin
            fp_dataa <= '0;
            fp_datab <= '0;
         end
         tag_valid <= {tag_valid[LATENCY-1:0], grant_any_c};
         tag_id[0] <= grant_id_c;
         for (int s = 1; s <= int'(LATENCY); s++) begin
            tag_id[s] <= tag_id[s-1];
         end
      end
   end

   // Per-requester in-flight counters; simultaneous issue and retire cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N); i++) begin
            outstanding[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(N); i++) begin
            if (hs_c[i] && !rsp_valid[i]) begin
               if (outstanding[i] != CNT_W'(MAX_OUT)) begin
                  outstanding[i] <= outstanding[i] + CNT_W'(1);
               end
            end else if (!hs_c[i] && rsp_valid[i]) begin
               if (outstanding[i] != '0) begin
                  outstanding[i] <= outstanding[i] - CNT_W'(1);
               end
            end
         end
      end
   end

   // Result leaves the adder in the same cycle its tag exits the last stage.
   always_comb begin
      rsp_valid = '0;
      if (tag_valid[LATENCY]) begin
         rsp_valid[tag_id[LATENCY]] = 1'b1;
      end
   end

   assign rsp_result = fp_result;
   assign busy       = |tag_valid;

endmodule

// File: tb/tb_ahfp_add_arbiter.sv
// Directed bench for ahfp_add_arbiter with a 7-stage behavioural adder stub.
module tb_ahfp_add_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_dataa;
   logic [127:0] req_datab;
`ifdef AHFP_ARB_SUB_EN
   logic [3:0]   req_op;
`endif
   logic [3:0]   rsp_valid;
   logic [31:0]  rsp_result;
   logic [31:0]  fp_dataa;
   logic [31:0]  fp_datab;
   logic [31:0]  fp_result;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ahfp_add_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_dataa  (req_dataa),
      .req_datab  (req_datab),
`ifdef AHFP_ARB_SUB_EN
      .req_op     (req_op),
`endif
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .fp_dataa   (fp_dataa),
      .fp_datab   (fp_datab),
      .fp_result  (fp_result),
      .busy       (busy)
   );

   // Known float sums for the directed vectors; integer sum otherwise to tag routing.
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3FC00000 && b == 32'h40200000) return 32'h40800000;
      if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
      return a + b;
   endfunction

   logic [31:0] pipe [7];
   always @(posedge clk) begin
      pipe[0] <= fadd(fp_dataa, fp_datab);
      for (int k = 1; k < 7; k++) pipe[k] <= pipe[k-1];
   end
   assign fp_result = pipe[6];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] op_a(input int i);
      return 32'h0000_0100 * 32'(i + 1);
   endfunction

   function automatic logic [31:0] op_b(input int i);
      return 32'h0001_0000 * 32'(i + 1);
   endfunction

   int seen_rsp;
   int seen_busy;

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_dataa = '0;
      req_datab = '0;
`ifdef AHFP_ARB_SUB_EN
      req_op    = '0;
`endif
      for (int i = 0; i < 4; i++) begin
         req_dataa[32*i +: 32] = op_a(i);
         req_datab[32*i +: 32] = op_b(i);
      end

      // Reset state with all requesters asking.
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_rsp",   32'(rsp_valid), 32'h0);
      check("rst_busy",  32'(busy),      32'h0);
      check("rst_fpa",   fp_dataa,       32'h0);
      check("rst_fpb",   fp_datab,       32'h0);

      // All four valid from reset release: rotating grants, in-order responses 8 cycles later.
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int j = 0; j < 24; j++) begin
         if (j > 0) tick();
         if (j == 16) req_valid = 4'h0;
         @(negedge clk);
         check("rr_ready", 32'(req_ready), (j < 16) ? 32'(1 << (j % 4)) : 32'h0);
         check("rr_rsp", 32'(rsp_valid), (j >= 8) ? 32'(1 << ((j - 8) % 4)) : 32'h0);
         if (j >= 8) check("rr_result", rsp_result, op_a((j - 8) % 4) + op_b((j - 8) % 4));
      end
      tick();
      @(negedge clk);
      check("rr_idle_busy", 32'(busy), 32'h0);

      // Single op on requester 0: 1.5 + 2.5, response exactly 8 cycles after handshake.
      tick();
      req_valid = 4'h1;
      req_dataa[31:0] = 32'h3FC00000;
      req_datab[31:0] = 32'h40200000;
      @(negedge clk);
      check("s0_ready", 32'(req_ready), 32'h1);
      for (int k = 1; k <= 9; k++) begin
         tick();
         req_valid = 4'h0;
         @(negedge clk);
         if (k == 1) begin
            check("s0_fpa", fp_dataa, 32'h3FC00000);
            check("s0_fpb", fp_datab, 32'h40200000);
         end
         if (k == 2) check("s0_fpa_idle", fp_dataa, 32'h0);
         if (k < 8) check("s0_norsp", 32'(rsp_valid), 32'h0);
         if (k == 8) begin
            check("s0_rsp", 32'(rsp_valid), 32'h1);
            check("s0_result", rsp_result, 32'h40800000);
            check("s0_busy", 32'(busy), 32'h1);
         end
         if (k == 9) begin
            check("s0_rsp_gone", 32'(rsp_valid), 32'h0);
            check("s0_busy_gone", 32'(busy), 32'h0);
         end
      end

      // Requester 2 alone: four credits, then one regrant per retiring response.
      tick();
      req_valid = 4'h4;
      for (int j = 0; j < 22; j++) begin
         if (j > 0) tick();
         @(negedge clk);
         check("cr_ready", 32'(req_ready), ((j % 8) < 4) ? 32'h4 : 32'h0);
         check("cr_rsp", 32'(rsp_valid), (j >= 8 && (j % 8) < 4) ? 32'h4 : 32'h0);
      end
      tick();
      req_valid = 4'h0;
      repeat (10) tick();
      @(negedge clk);
      check("cr_drain_busy", 32'(busy), 32'h0);

      // Two handshakes then reset: the in-flight ops must vanish.
      tick();
      for (int i = 0; i < 4; i++) begin
         req_dataa[32*i +: 32] = op_a(i);
         req_datab[32*i +: 32] = op_b(i);
      end
      req_valid = 4'h3;
      @(negedge clk);
      check("ab_ready0", 32'(req_ready), 32'h1);
      tick();
      @(negedge clk);
      check("ab_ready1", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'h0;
      repeat (2) tick();
      rst_n = 1'b0;
      @(negedge clk);
      check("ab_busy", 32'(busy), 32'h0);
      check("ab_fpa", fp_dataa, 32'h0);
      check("ab_rsp", 32'(rsp_valid), 32'h0);
      tick();
      rst_n = 1'b1;
      seen_rsp  = 0;
      seen_busy = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (rsp_valid != 4'h0) seen_rsp = 1;
         if (busy) seen_busy = 1;
         tick();
      end
      check("ab_norsp", 32'(seen_rsp), 32'h0);
      check("ab_nobusy", 32'(seen_busy), 32'h0);
      req_valid = 4'hF;
      @(negedge clk);
      check("ab_ptr_reset", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'h0;
      repeat (10) tick();

`ifdef AHFP_ARB_SUB_EN
      // Subtract on requester 1: 3.0 - 1.0.
      req_valid = 4'h2;
      req_op    = 4'h2;
      req_dataa[63:32] = 32'h40400000;
      req_datab[63:32] = 32'h3F800000;
      @(negedge clk);
      check("sub_ready", 32'(req_ready), 32'h2);
      for (int k = 1; k <= 8; k++) begin
         tick();
         req_valid = 4'h0;
         @(negedge clk);
         if (k == 1) check("sub_fpb", fp_datab, 32'hBF800000);
         if (k == 8) begin
            check("sub_rsp", 32'(rsp_valid), 32'h2);
            check("sub_result", rsp_result, 32'h40000000);
         end
      end
      req_op = '0;
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
